// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM states, slot geometry and UART register map.
package apb_pkg;

    localparam int unsigned APB_SLOT_BYTES = 4096;
    localparam int unsigned APB_ADDR_W     = 32;
    localparam int unsigned APB_DATA_W     = 32;
    localparam int unsigned APB_PADDR_W    = 12;
    localparam int unsigned APB_SLOT_W     = 4;

    localparam logic [APB_PADDR_W-1:0] UART_DIV   = 12'h000;
    localparam logic [APB_PADDR_W-1:0] UART_FRAME = 12'h004;
    localparam logic [APB_PADDR_W-1:0] UART_TX    = 12'h008;
    localparam logic [APB_PADDR_W-1:0] UART_RX    = 12'h00C;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

endpackage

// File: rtl/apb_slot_decode.sv
// Combinational byte address -> peripheral slot decode; one 4 KB window per slot above APB_BASE.
module apb_slot_decode
    import apb_pkg::*;
#(
    parameter logic [31:0] APB_BASE   = 32'h1000_0000,
    parameter int unsigned NUM_SLAVES = 4
) (
    input  logic [APB_ADDR_W-1:0] addr,
    output logic                  hit_c,
    output logic [APB_SLOT_W-1:0] slot_c
);

    logic [APB_ADDR_W-1:0] off;
    logic                  unused_c;

    // Offset wraps mod 2^32, so addresses below the base are excluded explicitly.
    assign off      = addr - APB_BASE;
    assign hit_c    = (addr >= APB_BASE) && (off[31:12] < 20'(NUM_SLAVES));
    assign slot_c   = off[15:12];
    assign unused_c = ^off[11:0];

endmodule

// File: rtl/core_apb3_bridge.sv
// Core load/store request bus to APB3 master bridge: one APB access per request,
// with slot decode, timeout and a held response.
module core_apb3_bridge
    import apb_pkg::*;
#(
    parameter logic [31:0] APB_BASE   = 32'h1000_0000,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                         pclk,
    input  logic                         presetn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [APB_ADDR_W-1:0]        req_addr,
    input  logic                         req_we,
    input  logic [APB_DATA_W-1:0]        req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [APB_DATA_W-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_SLAVES-1:0]        psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [APB_PADDR_W-1:0]       paddr,
    output logic [APB_DATA_W-1:0]        pwdata,
    input  logic [32*NUM_SLAVES-1:0]     prdata_v,
    input  logic [NUM_SLAVES-1:0]        pready_v,
    input  logic [NUM_SLAVES-1:0]        pslverr_v
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e            state;
    logic [APB_SLOT_W-1:0] slot_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  dec_hit_c;
    logic [APB_SLOT_W-1:0] dec_slot_c;
    logic [NUM_SLAVES-1:0] dec_onehot_c;
    logic                  sel_ready_c;
    logic                  sel_err_c;
    logic [APB_DATA_W-1:0] sel_rdata_c;
    logic                  timeout_c;

    apb_slot_decode #(
        .APB_BASE   (APB_BASE),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_decode (
        .addr   (req_addr),
        .hit_c  (dec_hit_c),
        .slot_c (dec_slot_c)
    );

    // Return-path mux keyed by the latched slot; one-hot select for the incoming request.
    always_comb begin
        sel_ready_c  = 1'b0;
        sel_err_c    = 1'b0;
        sel_rdata_c  = '0;
        dec_onehot_c = '0;
        for (int unsigned n = 0; n < NUM_SLAVES; n++) begin
            if (slot_q == APB_SLOT_W'(n)) begin
                sel_ready_c = pready_v[n];
                sel_err_c   = pslverr_v[n];
                sel_rdata_c = prdata_v[32*n +: 32];
            end
            dec_onehot_c[n] = (dec_slot_c == APB_SLOT_W'(n));
        end
    end

    assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            slot_q    <= '0;
            cnt_q     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (dec_hit_c) begin
                            state  <= SETUP;
                            slot_q <= dec_slot_c;
                            psel   <= dec_onehot_c;
                            pwrite <= req_we;
                            paddr  <= {req_addr[11:2], 2'b00};
                            pwdata <= req_wdata;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                    cnt_q   <= '0;
                end
                ACCESS: begin
                    if (sel_ready_c || timeout_c) begin
                        state     <= RESP;
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                    if (sel_ready_c) begin
                        rsp_rdata <= (pwrite || sel_err_c) ? '0 : sel_rdata_c;
                        rsp_err   <= sel_err_c;
                    end else if (timeout_c) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_apb3_bridge.sv
// Directed bench for core_apb3_bridge: write/read, decode misses, wait states, timeout, backpressure, reset.
module tb_core_apb3_bridge;

    logic         pclk = 1'b0;
    logic         presetn;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_we;
    logic [31:0]  req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [3:0]   psel;
    logic         penable;
    logic         pwrite;
    logic [11:0]  paddr;
    logic [31:0]  pwdata;
    logic [127:0] prdata_v;
    logic [3:0]   pready_v;
    logic [3:0]   pslverr_v;

    int n_chk  = 0;
    int n_fail = 0;

    int          lat;
    int          acc;
    logic [3:0]  ps;
    logic [11:0] pa;

    always #5 pclk = ~pclk;

    core_apb3_bridge #(
        .APB_BASE   (32'h1000_0000),
        .NUM_SLAVES (4),
        .TIMEOUT    (8)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata_v  (prdata_v),
        .pready_v  (pready_v),
        .pslverr_v (pslverr_v)
    );

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_psel"},      32'(psel),      32'h0);
        chk({tag, "_penable"},   32'(penable),   32'h0);
        chk({tag, "_pwrite"},    32'(pwrite),    32'h0);
        chk({tag, "_paddr"},     32'(paddr),     32'h0);
        chk({tag, "_pwdata"},    pwdata,         32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata,      32'h0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    endtask

    // Issue one request and follow it until rsp_valid, recording latency and bus activity.
    task automatic run_req(input string tag, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input int budget,
                           output int l, output int n_acc,
                           output logic [3:0] psel_or, output logic [11:0] paddr_seen);
        req_valid  = 1'b1;
        req_addr   = a;
        req_we     = we;
        req_wdata  = wd;
        n_acc      = 0;
        psel_or    = '0;
        paddr_seen = '0;
        step();
        req_valid = 1'b0;
        l = 1;
        while (rsp_valid !== 1'b1 && l < budget) begin
            if (penable === 1'b1) n_acc++;
            psel_or = psel_or | psel;
            if (psel !== 4'b0000) paddr_seen = paddr;
            step();
            l++;
        end
        chk({tag, "_rsp_arrived"}, 32'(rsp_valid), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        presetn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        prdata_v  = '0;
        pready_v  = '0;
        pslverr_v = '0;
        repeat (3) step();
        chk_reset_outputs("rst");
        presetn = 1'b1;
        step();

        // Write slot 0, zero-wait slave, cycle by cycle
        pready_v  = 4'b0001;
        req_valid = 1'b1;
        req_addr  = 32'h1000_0000;
        req_we    = 1'b1;
        req_wdata = 32'h0000_01B2;
        chk("t1_c0_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 1'b0;
        chk("t1_c1_psel",      32'(psel),      32'h1);
        chk("t1_c1_penable",   32'(penable),   32'h0);
        chk("t1_c1_paddr",     32'(paddr),     32'h000);
        chk("t1_c1_pwdata",    pwdata,         32'h0000_01B2);
        chk("t1_c1_pwrite",    32'(pwrite),    32'h1);
        chk("t1_c1_req_ready", 32'(req_ready), 32'h0);
        step();
        chk("t1_c2_psel",      32'(psel),      32'h1);
        chk("t1_c2_penable",   32'(penable),   32'h1);
        chk("t1_c2_pwdata",    pwdata,         32'h0000_01B2);
        step();
        chk("t1_c3_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_c3_rsp_err",   32'(rsp_err),   32'h0);
        chk("t1_c3_rsp_rdata", rsp_rdata,      32'h0);
        chk("t1_c3_psel",      32'(psel),      32'h0);
        chk("t1_c3_penable",   32'(penable),   32'h0);
        step();
        chk("t1_c4_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t1_c4_req_ready", 32'(req_ready), 32'h1);

        // Read slot 1 register 0x00C
        pready_v        = 4'b0010;
        prdata_v[63:32] = 32'h8000_0041;
        run_req("t2", 32'h1000_100C, 1'b0, 32'h0, 20, lat, acc, ps, pa);
        chk("t2_latency", 32'(lat),   32'd3);
        chk("t2_access",  32'(acc),   32'd1);
        chk("t2_psel",    32'(ps),    32'b0010);
        chk("t2_paddr",   32'(pa),    32'h00C);
        chk("t2_rdata",   rsp_rdata,  32'h8000_0041);
        chk("t2_err",     32'(rsp_err), 32'h0);
        step();

        // Decode misses: above the window, just below the base, one past the last slot
        pready_v = 4'b1111;
        run_req("t3a", 32'h2000_0000, 1'b0, 32'h0, 20, lat, acc, ps, pa);
        chk("t3a_latency", 32'(lat),     32'd1);
        chk("t3a_psel",    32'(ps),      32'h0);
        chk("t3a_access",  32'(acc),     32'd0);
        chk("t3a_err",     32'(rsp_err), 32'h1);
        chk("t3a_rdata",   rsp_rdata,    32'h0);
        step();
        run_req("t3b", 32'h0FFF_FFFC, 1'b0, 32'h0, 20, lat, acc, ps, pa);
        chk("t3b_latency", 32'(lat),     32'd1);
        chk("t3b_psel",    32'(ps),      32'h0);
        chk("t3b_err",     32'(rsp_err), 32'h1);
        step();
        run_req("t3c", 32'h1000_4000, 1'b0, 32'h0, 20, lat, acc, ps, pa);
        chk("t3c_psel",    32'(ps),      32'h0);
        chk("t3c_err",     32'(rsp_err), 32'h1);
        step();

        // Last word of the last slot is a hit
        pready_v          = 4'b1000;
        prdata_v[127:96]  = 32'hDEAD_BEEF;
        run_req("t3d", 32'h1000_3FFF, 1'b0, 32'h0, 20, lat, acc, ps, pa);
        chk("t3d_latency", 32'(lat),     32'd3);
        chk("t3d_psel",    32'(ps),      32'b1000);
        chk("t3d_paddr",   32'(pa),      32'hFFC);
        chk("t3d_rdata",   rsp_rdata,    32'hDEAD_BEEF);
        chk("t3d_err",     32'(rsp_err), 32'h0);
        step();

        // Slot 2 with three wait states then pslverr
        pready_v  = 4'b0000;
        pslverr_v = 4'b0100;
        prdata_v  = '0;
        req_valid = 1'b1;
        req_addr  = 32'h1000_2008;
        req_we    = 1'b0;
        step();
        req_valid = 1'b0;
        chk("t4_setup_psel",    32'(psel),    32'b0100);
        chk("t4_setup_penable", 32'(penable), 32'h0);
        chk("t4_setup_paddr",   32'(paddr),   32'h008);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_access_psel",    32'(psel),      32'b0100);
            chk("t4_access_penable", 32'(penable),   32'h1);
            chk("t4_access_rsp",     32'(rsp_valid), 32'h0);
            if (i == 3) pready_v = 4'b0100;
        end
        step();
        chk("t4_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t4_rsp_err",   32'(rsp_err),   32'h1);
        chk("t4_rsp_rdata", rsp_rdata,      32'h0);
        chk("t4_psel_drop", 32'(psel),      32'h0);
        chk("t4_pen_drop",  32'(penable),   32'h0);
        step();
        pready_v  = 4'b0000;
        pslverr_v = 4'b0000;

        // Timeout after 8 ACCESS cycles, then a normal request is still accepted
        run_req("t5", 32'h1000_0004, 1'b0, 32'h0, 30, lat, acc, ps, pa);
        chk("t5_latency", 32'(lat),     32'd10);
        chk("t5_access",  32'(acc),     32'd8);
        chk("t5_psel",    32'(ps),      32'b0001);
        chk("t5_err",     32'(rsp_err), 32'h1);
        chk("t5_rdata",   rsp_rdata,    32'h0);
        chk("t5_psel_drop", 32'(psel),  32'h0);
        chk("t5_pen_drop",  32'(penable), 32'h0);
        step();
        chk("t5_req_ready", 32'(req_ready), 32'h1);
        pready_v = 4'b0010;
        run_req("t5n", 32'h1000_1000, 1'b1, 32'h0000_00A5, 20, lat, acc, ps, pa);
        chk("t5n_latency", 32'(lat),     32'd3);
        chk("t5n_err",     32'(rsp_err), 32'h0);
        chk("t5n_psel",    32'(ps),      32'b0010);
        step();

        // Response backpressure for 5 cycles
        rsp_ready       = 1'b0;
        prdata_v[63:32] = 32'h5555_AAAA;
        run_req("t6", 32'h1000_1010, 1'b0, 32'h0, 20, lat, acc, ps, pa);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_hold_valid", 32'(rsp_valid), 32'h1);
            chk("t6_hold_rdata", rsp_rdata,      32'h5555_AAAA);
            chk("t6_hold_err",   32'(rsp_err),   32'h0);
            chk("t6_hold_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        step();
        chk("t6_release_valid", 32'(rsp_valid), 32'h0);
        chk("t6_release_ready", 32'(req_ready), 32'h1);

        // Reset asserted in the middle of an ACCESS phase
        pready_v  = 4'b0000;
        req_valid = 1'b1;
        req_addr  = 32'h1000_2000;
        req_we    = 1'b1;
        req_wdata = 32'h0000_0077;
        step();
        req_valid = 1'b0;
        step();
        chk("t6r_access_pen",  32'(penable), 32'h1);
        chk("t6r_access_psel", 32'(psel),    32'b0100);
        presetn = 1'b0;
        step();
        chk_reset_outputs("t6r");
        presetn = 1'b1;
        repeat (3) step();
        chk("t6r_no_rsp",  32'(rsp_valid), 32'h0);
        chk("t6r_no_psel", 32'(psel),      32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
